// File: rtl/div_share_sched_if.sv
// Requester/consumer bundle for the shared divide scheduler.
// Carries res_rem only when DIV_SHARE_SCHED_REM_EN is defined.
interface div_share_sched_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic [WIDTH-1:0]      res_quot;
    logic                  res_dz;
`ifdef DIV_SHARE_SCHED_REM_EN
    logic [WIDTH-1:0]      res_rem;
`endif

    // master: issuers and result consumer; slave: the scheduler
    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_quot, res_dz
`ifdef DIV_SHARE_SCHED_REM_EN
        , input res_rem
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_quot, res_dz
`ifdef DIV_SHARE_SCHED_REM_EN
        , output res_rem
`endif
    );
endinterface

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one multicycle unsigned divider among NREQ issuers.
// Optional remainder output enabled by DIV_SHARE_SCHED_REM_EN.
module div_share_sched #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    div_share_sched_if.slave  bus,
    output logic              busy
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b;
    logic [IDW-1:0]   op_id;
    logic [IDW-1:0]   gid;
    logic             found;
    logic [NREQ-1:0]  grant;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [WIDTH-1:0] quot_c;
    logic             dz_c;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
    end

    // divider output is a multicycle path from the operand registers
    assign dz_c   = (op_b == '0);
    assign quot_c = dz_c ? '0 : op_a / op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // round-robin search plus next-state decode
    always_comb begin
        state_d = state;
        found   = 1'b0;
        gid     = '0;
        grant   = '0;
        case (state)
            IDLE: begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    if (!found && bus.req_valid[IDW'((32'(rr_ptr) + k) % NREQ)]) begin
                        found = 1'b1;
                        gid   = IDW'((32'(rr_ptr) + k) % NREQ);
                    end
                end
                if (found) begin
                    grant   = NREQ'(1) << gid;
                    state_d = CALC;
                end
            end
            CALC:    if (cnt == '0) state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = rst_n ? grant : '0;
    assign bus.res_valid = (state == DONE);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            cnt          <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_id        <= '0;
            bus.res_id   <= '0;
            bus.res_quot <= '0;
            bus.res_dz   <= 1'b0;
`ifdef DIV_SHARE_SCHED_REM_EN
            bus.res_rem  <= '0;
`endif
        end else begin
            if (state == IDLE && found) begin
                op_a   <= a_arr[gid];
                op_b   <= b_arr[gid];
                op_id  <= gid;
                rr_ptr <= (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);
                cnt    <= CW'(LAT-1);
            end
            if (state == CALC) begin
                if (cnt == '0) begin
                    bus.res_quot <= quot_c;
                    bus.res_dz   <= dz_c;
                    bus.res_id   <= op_id;
`ifdef DIV_SHARE_SCHED_REM_EN
                    bus.res_rem  <= dz_c ? op_a : op_a % op_b;
`endif
                end else begin
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_div_share_sched.sv
// Directed bench for div_share_sched: vector table plus reset, round-robin
// and backpressure sequences.
module tb_div_share_sched;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned LAT   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    div_share_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus();

    div_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] a;      // {a3,a2,a1,a0}
        logic [31:0] b;
        logic [3:0]  grant;
        logic [1:0]  id;
        logic [7:0]  quot;
        logic        dz;
        logic [7:0]  rem;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int n, input vec_t v);
        @(negedge clk);
        bus.req_valid = v.valid;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        #1 chk($sformatf("v%0d grant", n), 32'(bus.req_ready), 32'(v.grant));
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        chk($sformatf("v%0d busy", n), 32'(busy), 32'd1);
        chk($sformatf("v%0d calc_ready", n), 32'(bus.req_ready), 32'd0);
        repeat (LAT-1) begin
            @(negedge clk);
            chk($sformatf("v%0d early_valid", n), 32'(bus.res_valid), 32'd0);
        end
        @(negedge clk);
        chk($sformatf("v%0d res_valid", n), 32'(bus.res_valid), 32'd1);
        chk($sformatf("v%0d id", n), 32'(bus.res_id), 32'(v.id));
        chk($sformatf("v%0d quot", n), 32'(bus.res_quot), 32'(v.quot));
        chk($sformatf("v%0d dz", n), 32'(bus.res_dz), 32'(v.dz));
`ifdef DIV_SHARE_SCHED_REM_EN
        chk($sformatf("v%0d rem", n), 32'(bus.res_rem), 32'(v.rem));
`endif
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk($sformatf("v%0d idle_valid", n), 32'(bus.res_valid), 32'd0);
        chk($sformatf("v%0d idle_busy", n), 32'(busy), 32'd0);
    endtask

    logic [7:0] rr_quot [4];
    int         gcyc    [8];
    int         gid_log [8];
    int         ngrant;
    int         nres;
    int         exp_order [5];

    initial begin
        // rr_ptr evolves 0->1->3->0->2->1->0->2 across the table
        vecs[0] = '{4'b0001, {8'd170, 8'd170, 8'd170, 8'd100}, {8'd1, 8'd1, 8'd1, 8'd7},
                    4'b0001, 2'd0, 8'd14, 1'b0, 8'd2};
        vecs[1] = '{4'b0100, {8'd170, 8'd55, 8'd170, 8'd170}, {8'd1, 8'd0, 8'd1, 8'd1},
                    4'b0100, 2'd2, 8'd0, 1'b1, 8'd55};
        vecs[2] = '{4'b1111, {8'd200, 8'd9, 8'd9, 8'd9}, {8'd1, 8'd2, 8'd2, 8'd2},
                    4'b1000, 2'd3, 8'd200, 1'b0, 8'd0};
        vecs[3] = '{4'b0110, {8'd9, 8'd9, 8'd0, 8'd9}, {8'd2, 8'd2, 8'd5, 8'd2},
                    4'b0010, 2'd1, 8'd0, 1'b0, 8'd0};
        vecs[4] = '{4'b0011, {8'd9, 8'd9, 8'd9, 8'd255}, {8'd2, 8'd2, 8'd2, 8'd16},
                    4'b0001, 2'd0, 8'd15, 1'b0, 8'd15};
        vecs[5] = '{4'b1000, {8'd7, 8'd9, 8'd9, 8'd9}, {8'd9, 8'd2, 8'd2, 8'd2},
                    4'b1000, 2'd3, 8'd0, 1'b0, 8'd7};
        vecs[6] = '{4'b1110, {8'd9, 8'd9, 8'd250, 8'd9}, {8'd2, 8'd2, 8'd250, 8'd2},
                    4'b0010, 2'd1, 8'd1, 1'b0, 8'd0};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;

        #1 chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // reset mid-CALC: req1 9/3 accepted, then aborted
        @(negedge clk);
        bus.req_valid = 4'b0010;
        bus.req_a     = {8'd0, 8'd0, 8'd9, 8'd0};
        bus.req_b     = {8'd1, 8'd1, 8'd3, 8'd1};
        #1 chk("abort_grant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #3 rst_n = 1'b0;
        #1 chk("async_busy", 32'(busy), 32'd0);
        chk("async_ready", 32'(bus.req_ready), 32'd0);
        chk("async_valid", 32'(bus.res_valid), 32'd0);
        chk("async_id", 32'(bus.res_id), 32'd0);
        chk("async_quot", 32'(bus.res_quot), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;
        for (int c = 0; c < int'(LAT) + 2; c++) begin
            #1 chk("abort_no_valid", 32'(bus.res_valid), 32'd0);
            @(negedge clk);
        end

        // round robin with all requesters valid and consumer always ready
        rr_quot[0] = 8'd6; rr_quot[1] = 8'd9; rr_quot[2] = 8'd8; rr_quot[3] = 8'd11;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
        bus.req_a     = {8'd99, 8'd60, 8'd45, 8'd20};
        bus.req_b     = {8'd9, 8'd7, 8'd5, 8'd3};
        bus.req_valid = 4'b1111;
        bus.res_ready = 1'b1;
        ngrant = 0;
        nres   = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.req_ready != '0 && ngrant < 8) begin
                gcyc[ngrant] = c;
                gid_log[ngrant] = (bus.req_ready == 4'b0001) ? 0 :
                                  (bus.req_ready == 4'b0010) ? 1 :
                                  (bus.req_ready == 4'b0100) ? 2 :
                                  (bus.req_ready == 4'b1000) ? 3 : 99;
                ngrant++;
            end
            if (bus.res_valid && nres < 5) begin
                chk($sformatf("rr_res%0d_id", nres), 32'(bus.res_id), 32'(exp_order[nres]));
                chk($sformatf("rr_res%0d_quot", nres), 32'(bus.res_quot),
                    32'(rr_quot[exp_order[nres]]));
                nres++;
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        chk("rr_grant_count", 32'(ngrant), 32'd5);
        chk("rr_result_count", 32'(nres), 32'd5);
        for (int g = 0; g < 5; g++) begin
            if (g < ngrant) begin
                chk($sformatf("rr_grant%0d_id", g), 32'(gid_log[g]), 32'(exp_order[g]));
                chk($sformatf("rr_grant%0d_cycle", g), 32'(gcyc[g]), 32'(g * int'(LAT + 2)));
            end
        end

        // backpressure: rr_ptr is 1 after the last round-robin grant
        @(negedge clk);
        bus.req_valid = 4'b0010;
        bus.req_a     = {8'd5, 8'd5, 8'd200, 8'd5};
        bus.req_b     = {8'd1, 8'd1, 8'd3, 8'd1};
        #1 chk("bp_grant", 32'(bus.req_ready), 32'b0010);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        repeat (LAT) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_quot", 32'(bus.res_quot), 32'd66);
            chk("bp_id", 32'(bus.res_id), 32'd1);
            chk("bp_dz", 32'(bus.res_dz), 32'd0);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("bp_release_valid", 32'(bus.res_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_next_grant", 32'(bus.req_ready), 32'b0100);
        bus.req_valid = '0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
